// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO read port and serialises them
// LSB first with a start bit, optional parity and one or two stop bits.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_not_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        baud_cnt_r;
  logic [IDX_W-1:0]        bit_idx_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic                    parity_r;
  logic                    tx_r;
  logic                    bit_end_s;
  logic [DATA_WIDTH-1:0]   shift_next_s;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data);
    if (PARITY == 2) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

  assign bit_end_s    = (baud_cnt_r == CNT_LAST);
  assign shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};

  assign fifo_rd = (state_r == ST_FETCH);
  assign busy    = (state_r != ST_IDLE);
  assign tx      = tx_r;

  // Frame sequencer: state, baud counter, bit index, shift register and line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      parity_r   <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r       <= 1'b1;
          baud_cnt_r <= {CNT_W{1'b0}};
          bit_idx_r  <= {IDX_W{1'b0}};
          if (fifo_not_empty) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // Head word is stable here, so capture it and drive the start bit next cycle.
        ST_FETCH: begin
          shift_r    <= fifo_data;
          parity_r   <= calc_parity(fifo_data);
          baud_cnt_r <= {CNT_W{1'b0}};
          bit_idx_r  <= {IDX_W{1'b0}};
          tx_r       <= 1'b0;
          state_r    <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            tx_r       <= shift_r[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (bit_idx_r == IDX_LAST) begin
              bit_idx_r <= {IDX_W{1'b0}};
              if (HAS_PARITY) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              shift_r   <= shift_next_s;
              tx_r      <= shift_next_s[0];
              bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            tx_r       <= 1'b1;
            state_r    <= ST_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        // The bit index doubles as the stop-bit counter.
        ST_STOP: begin
          tx_r <= 1'b1;
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (bit_idx_r == STOP_LAST) begin
              bit_idx_r <= {IDX_W{1'b0}};
              state_r   <= ST_IDLE;
            end else begin
              bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          tx_r    <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitters (no/even/odd parity, 1/1/2 stop bits)
// drain a shared byte stream; per-cycle line waveforms are compared to frames.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ne, rd_w, tx_w, busy_w;
  logic [7:0] dat [3];

  logic [7:0]  mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr [3] = '{0, 0, 0};
  int          pops [3] = '{0, 0, 0};
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [19:0] exp_q0 [$];
  logic [19:0] exp_q1 [$];
  logic [19:0] exp_q2 [$];

  logic        ne_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic        rd_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic        last_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic        had_more [3] = '{1'b0, 1'b0, 1'b0};
  int          last_fetch [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_uart_tx #(
      .DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY(g), .STOP_BITS((g == 2) ? 2 : 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .fifo_not_empty(ne[g]), .fifo_data(dat[g]),
      .fifo_rd(rd_w[g]), .tx(tx_w[g]), .busy(busy_w[g])
    );
  end

  // FIFO model: combinational head word, one read pointer per transmitter.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ne[i]  = (rd_ptr[i] != wr_ptr);
      dat[i] = mem[rd_ptr[i][9:0]];
    end
  end

  // FIFO model read side and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) pops[i] <= pops[i] + 1;
      if (rd_w[i] && rd_ptr[i] != wr_ptr) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int period(input int d);
    return (1 + 8 + ((d != 0) ? 1 : 0) + ((d == 2) ? 2 : 1)) * C + 2;
  endfunction

  // Serial bit k of the frame lives at bit k; the bit count sits in [19:16].
  function automatic logic [19:0] build_frame(input logic [7:0] b, input int d);
    logic [15:0] bits;
    int n;
    bits = 16'h0000;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      bits[n] = b[k];
      n++;
    end
    if (d != 0) begin
      bits[n] = (($countones(b) % 2) == 1) ^ (d == 2);
      n++;
    end
    for (int s = 0; s < ((d == 2) ? 2 : 1); s++) begin
      bits[n] = 1'b1;
      n++;
    end
    return {4'(n), bits};
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [19:0] qpop(input int d);
    case (d)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
    exp_q0.push_back(build_frame(b, 0));
    exp_q1.push_back(build_frame(b, 1));
    exp_q2.push_back(build_frame(b, 2));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-strobe rules and FETCH-to-FETCH spacing while the FIFO stays non-empty.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        last_valid[d] <= 1'b0;
      end else if (rd_w[d]) begin
        chk($sformatf("rd_after_not_empty_dut%0d", d), int'(ne_prev[d]), 1);
        chk($sformatf("rd_not_back_to_back_dut%0d", d), int'(rd_prev[d]), 0);
        if (last_valid[d] && had_more[d])
          chk($sformatf("fetch_spacing_dut%0d", d), cyc - last_fetch[d], period(d));
        last_fetch[d] <= cyc;
        last_valid[d] <= 1'b1;
        had_more[d]   <= ((wr_ptr - rd_ptr[d]) > 1);
      end
      ne_prev[d] <= ne[d];
      rd_prev[d] <= rd_w[d];
    end
  end

  // UART monitor: on the first low cycle, pop the expected frame and compare every cycle.
  task automatic mon(input int d);
    logic        last_rd;
    logic [19:0] fr;
    int          n, bad_k, bad_busy;
    bit          aborted;
    last_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_w[d] == 1'b0) begin
        chk($sformatf("fetch_before_start_dut%0d", d), int'(last_rd), 1);
        if (qsize(d) == 0) begin
          chk($sformatf("frame_expected_dut%0d", d), 0, 1);
        end else begin
          fr = qpop(d);
          n = int'(fr[19:16]);
          bad_k = -1;
          bad_busy = (busy_w[d] == 1'b1) ? 0 : 1;
          aborted = 1'b0;
          for (int k = 1; k < n * C; k++) begin
            @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (tx_w[d] !== fr[k / C] && bad_k < 0) bad_k = k;
            if (busy_w[d] !== 1'b1) bad_busy = 1;
          end
          if (!aborted) begin
            chk($sformatf("frame_tx_dut%0d_byte%02h_first_bad_cycle", d, fr[8:1]), bad_k, -1);
            chk($sformatf("frame_busy_dut%0d", d), bad_busy, 0);
            @(negedge clk);
            if (rst_n) chk($sformatf("busy_low_after_frame_dut%0d", d), int'(busy_w[d]), 0);
          end
        end
      end
      last_rd = rd_w[d];
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(rd_ptr[0] == wr_ptr && rd_ptr[1] == wr_ptr &&
                           rd_ptr[2] == wr_ptr && busy_w == 3'b000)) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_budget", int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset idle with an empty FIFO.
    repeat (100) begin
      @(negedge clk);
      chk("idle_tx", int'(tx_w), 7);
      chk("idle_rd", int'(rd_w), 0);
      chk("idle_busy", int'(busy_w), 0);
    end

    // Single bytes exercising both parity senses.
    tick();
    push(8'hA5);
    wait_drain(400);
    tick();
    push(8'h07);
    wait_drain(400);

    // Back-to-back frames.
    tick();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain(1000);

    // Reset in the middle of data bit 3 of 0x55; 0x99 must follow intact.
    tick();
    push(8'h55);
    push(8'h99);
    n = 0;
    while (n < 50 && rd_w[0] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_seen_before_reset", int'(n < 50), 1);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx_high", int'(tx_w), 7);
    chk("reset_busy_low", int'(busy_w), 0);
    chk("reset_rd_low", int'(rd_w), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain(600);

    // Randomised bytes with random gaps.
    for (int i = 0; i < 30; i++) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_drain(3000);

    // Full 128-entry drain with an incrementing pattern.
    tick();
    for (int i = 0; i < 128; i++) push(8'(i));
    wait_drain(128 * 52 + 200);

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pop_count_dut%0d", d), pops[d], wr_ptr);
      chk($sformatf("frames_outstanding_dut%0d", d), qsize(d), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
